// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the two-requester SDRAM port arbiter:
// FSM state encoding and the SDRAM word-address range.
package sdram_arbiter_pkg;

  // SDRAM word address spans adr[21:1] (16-bit words).
  localparam int ADR_HI = 21;
  localparam int ADR_LO = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_REL  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_timeout.sv
// Grant-timeout counter. Counts enabled cycles since the last clear and
// flags the cycle in which the count would reach the limit. A zero limit
// never expires.
module arb_timeout #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Combinational so the FSM can leave the grant on the same edge the
  // limit is reached.
  assign expired = en && (limit != '0) && (cnt == limit - CNT_W'(1));

  // Stall counter: cleared outside a grant, advances on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired && (limit != '0)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of a single SDRAM port.
// States: IDLE -> GNT0/GNT1 -> REL -> IDLE. All port outputs are gated by
// the state, so an asynchronous reset drops s_stb immediately.
// Handshake: a requester holds mX_stb until it has seen mX_ack; the
// granted requester's signals pass combinationally to the s_* port and
// s_ack/s_dat pass back; the non-granted side sees ack=0, rdat=0.
// Optional feature: define SDRAM_ARB_RR_EN for round-robin priority on
// simultaneous requests; otherwise requester 0 always wins.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int TMO_CYCLES = 255
) (
  input  logic                 clk_p,
  input  logic                 rst_n,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [1:0]           m0_sel,
  input  logic [ADR_HI:ADR_LO] m0_adr,
  input  logic [15:0]          m0_wdat,
  output logic [15:0]          m0_rdat,
  output logic                 m0_ack,
  output logic                 m0_err,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [1:0]           m1_sel,
  input  logic [ADR_HI:ADR_LO] m1_adr,
  input  logic [15:0]          m1_wdat,
  output logic [15:0]          m1_rdat,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [1:0]           s_sel,
  output logic [ADR_HI:ADR_LO] s_adr,
  output logic [15:0]          s_out,
  input  logic [15:0]          s_dat,
  input  logic                 s_ack,
  input  logic                 s_ready,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TMO_CYCLES);

  arb_state_t state, state_next, both_pick;
  logic       tmo_en, tmo_clr, tmo_expired;

  assign dbg_state = state;

  // The counter only runs while the granted requester is still waiting.
  assign tmo_en  = ((state == ST_GNT0) && m0_stb && !s_ack) ||
                   ((state == ST_GNT1) && m1_stb && !s_ack);
  assign tmo_clr = (state != ST_GNT0) && (state != ST_GNT1);

  arb_timeout #(.CNT_W(CNT_W)) u_timeout (
    .clk     (clk_p),
    .rst_n   (rst_n),
    .en      (tmo_en),
    .clr     (tmo_clr),
    .limit   (TMO_LIMIT),
    .expired (tmo_expired)
  );

`ifdef SDRAM_ARB_RR_EN
  logic ptr;

  // Priority pointer: after each grant ends, favour the other requester.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (((state == ST_GNT0) || (state == ST_GNT1)) && (state_next == ST_REL)) begin
      ptr <= (state == ST_GNT0);
    end
  end

  assign both_pick = ptr ? ST_GNT1 : ST_GNT0;
`else
  assign both_pick = ST_GNT0;
`endif

  // State register.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timeout error: one registered pulse on the edge that forces REL.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      m0_err <= (state == ST_GNT0) && tmo_expired;
      m1_err <= (state == ST_GNT1) && tmo_expired;
    end
  end

  // Next-state and state-gated port muxing.
  always_comb begin
    state_next = state;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_sel      = '0;
    s_adr      = '0;
    s_out      = '0;
    m0_ack     = 1'b0;
    m0_rdat    = '0;
    m1_ack     = 1'b0;
    m1_rdat    = '0;
    case (state)
      ST_IDLE: begin
        if (s_ready) begin
          if (m0_stb && m1_stb) state_next = both_pick;
          else if (m0_stb)      state_next = ST_GNT0;
          else if (m1_stb)      state_next = ST_GNT1;
        end
      end
      ST_GNT0: begin
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_sel   = m0_sel;
        s_adr   = m0_adr;
        s_out   = m0_wdat;
        m0_ack  = s_ack & m0_stb;
        m0_rdat = s_dat;
        if (!m0_stb || tmo_expired) state_next = ST_REL;
      end
      ST_GNT1: begin
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_sel   = m1_sel;
        s_adr   = m1_adr;
        s_out   = m1_wdat;
        m1_ack  = s_ack & m1_stb;
        m1_rdat = s_dat;
        if (!m1_stb || tmo_expired) state_next = ST_REL;
      end
      ST_REL:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter (built with TMO_CYCLES = 8).
// Inputs are driven on the falling edge and outputs sampled 1 time unit
// later; read/write data expectations go through a scoreboard queue.
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int TMO = 8;
  localparam int NVEC = 8;

  logic        clk_p = 1'b0;
  logic        rst_n;
  logic        m0_stb, m0_we, m0_ack, m0_err;
  logic [1:0]  m0_sel;
  logic [21:1] m0_adr;
  logic [15:0] m0_wdat, m0_rdat;
  logic        m1_stb, m1_we, m1_ack, m1_err;
  logic [1:0]  m1_sel;
  logic [21:1] m1_adr;
  logic [15:0] m1_wdat, m1_rdat;
  logic        s_stb, s_we, s_ack, s_ready;
  logic [1:0]  s_sel;
  logic [21:1] s_adr;
  logic [15:0] s_out, s_dat;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        m;
    logic        we;
    logic [1:0]  sel;
    logic [21:1] adr;
    logic [15:0] wdat;
    logic [15:0] sdat;
    int          ack_dly;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[NVEC];

  sdram_arbiter #(.TMO_CYCLES(TMO)) dut (
    .clk_p(clk_p), .rst_n(rst_n),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_wdat(m0_wdat), .m0_rdat(m0_rdat), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_wdat(m1_wdat), .m1_rdat(m1_rdat), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr), .s_out(s_out),
    .s_dat(s_dat), .s_ack(s_ack), .s_ready(s_ready), .dbg_state(dbg_state)
  );

  // Clock: 10 time-unit period.
  always #5 clk_p = ~clk_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input string name, input logic [15:0] act);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got 0x%0h, expected an entry in the empty scoreboard", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(act), 32'(e));
    end
  endtask

  function automatic logic ack_of(input logic m);
    return m ? m1_ack : m0_ack;
  endfunction

  function automatic logic [15:0] rdat_of(input logic m);
    return m ? m1_rdat : m0_rdat;
  endfunction

  function automatic logic [1:0] gnt_of(input logic m);
    return m ? ST_GNT1 : ST_GNT0;
  endfunction

  task automatic set_stb(input logic m, input logic v);
    if (m) m1_stb = v;
    else   m0_stb = v;
  endtask

  task automatic drive_req(input logic m, input logic we, input logic [1:0] sel,
                           input logic [21:1] adr, input logic [15:0] wdat);
    if (m) begin
      m1_stb = 1'b1; m1_we = we; m1_sel = sel; m1_adr = adr; m1_wdat = wdat;
    end else begin
      m0_stb = 1'b1; m0_we = we; m0_sel = sel; m0_adr = adr; m0_wdat = wdat;
    end
  endtask

  // Drop the request at the next falling edge and follow REL -> IDLE.
  task automatic release_req(input logic m, input string tag);
    @(negedge clk_p);
    set_stb(m, 1'b0);
    s_ack = 1'b0;
    @(negedge clk_p); #1;
    check({tag, "_rel_state"}, 32'(dbg_state), 32'(ST_REL));
    check({tag, "_rel_no_stb"}, 32'(s_stb), 0);
    @(negedge clk_p); #1;
    check({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // One complete transaction from a vector record.
  task automatic run_xact(input vec_t v);
    @(negedge clk_p);
    drive_req(v.m, v.we, v.sel, v.adr, v.wdat);
    s_dat = v.sdat;
    s_ack = 1'b0;
    exp_q.push_back(v.exp_data);
    #1;
    check("vec_idle_no_stb", 32'(s_stb), 0);
    @(negedge clk_p); #1;
    check("vec_grant_state", 32'(dbg_state), 32'(gnt_of(v.m)));
    check("vec_s_stb", 32'(s_stb), 1);
    check("vec_s_adr", 32'(s_adr), 32'(v.adr));
    check("vec_s_we", 32'(s_we), 32'(v.we));
    check("vec_s_sel", 32'(s_sel), 32'(v.sel));
    check("vec_s_out", 32'(s_out), 32'(v.wdat));
    for (int i = 1; i < v.ack_dly; i++) begin
      check("vec_ack_wait", 32'(ack_of(v.m)), 0);
      check("vec_other_ack", 32'(ack_of(!v.m)), 0);
      @(negedge clk_p); #1;
    end
    s_ack = 1'b1;
    #1;
    check("vec_ack", 32'(ack_of(v.m)), 1);
    check("vec_other_ack", 32'(ack_of(!v.m)), 0);
    check("vec_other_rdat", 32'(rdat_of(!v.m)), 0);
    sb_pop(v.we ? "vec_wr_data" : "vec_rd_data", v.we ? s_out : rdat_of(v.m));
    release_req(v.m, "vec");
  endtask

  initial begin
    logic win;

    // ---- reset: outputs gated even with a request and s_ready present ----
    rst_n = 1'b0;
    m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 2'b11; m0_adr = 21'h00055; m0_wdat = 16'h7777;
    m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 2'b00; m1_adr = '0; m1_wdat = '0;
    s_dat = 16'h9999; s_ack = 1'b1; s_ready = 1'b1;
    repeat (3) @(negedge clk_p);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_s_stb", 32'(s_stb), 0);
    check("rst_s_we", 32'(s_we), 0);
    check("rst_s_adr", 32'(s_adr), 0);
    check("rst_s_out", 32'(s_out), 0);
    check("rst_m0_ack", 32'(m0_ack), 0);
    check("rst_m0_rdat", 32'(m0_rdat), 0);
    check("rst_errs", 32'({m0_err, m1_err}), 0);
    m0_stb = 1'b0; s_ack = 1'b0;
    @(negedge clk_p);
    rst_n = 1'b1;

    // ---- vector table ----
    vecs[0] = '{m:1'b0, we:1'b0, sel:2'b11, adr:21'h00100, wdat:16'h0000, sdat:16'h1234, ack_dly:4, exp_data:16'h1234};
    vecs[1] = '{m:1'b1, we:1'b1, sel:2'b10, adr:21'h1ABCD, wdat:16'hBEEF, sdat:16'hDEAD, ack_dly:2, exp_data:16'hBEEF};
    vecs[2] = '{m:1'b0, we:1'b1, sel:2'b01, adr:21'h1FFFFF, wdat:16'h00FF, sdat:16'h0000, ack_dly:1, exp_data:16'h00FF};
    vecs[3] = '{m:1'b1, we:1'b0, sel:2'b11, adr:21'h000000, wdat:16'h1111, sdat:16'hA5A5, ack_dly:3, exp_data:16'hA5A5};
    for (int i = 4; i < NVEC; i++) begin
      vecs[i].m       = 1'($urandom_range(0, 1));
      vecs[i].we      = 1'($urandom_range(0, 1));
      vecs[i].sel     = 2'($urandom_range(0, 3));
      vecs[i].adr     = 21'($urandom());
      vecs[i].wdat    = 16'($urandom());
      vecs[i].sdat    = 16'($urandom());
      vecs[i].ack_dly = $urandom_range(1, 5);
      vecs[i].exp_data = vecs[i].we ? vecs[i].wdat : vecs[i].sdat;
    end
    for (int i = 0; i < NVEC; i++) run_xact(vecs[i]);

    // ---- simultaneous requests, three rounds ----
    @(negedge clk_p);
    for (int r = 0; r < 3; r++) begin
`ifdef SDRAM_ARB_RR_EN
      win = (r == 1);
`else
      win = 1'b0;
`endif
      drive_req(1'b0, 1'b0, 2'b11, 21'(r), 16'h0);
      drive_req(1'b1, 1'b0, 2'b11, 21'(16'h0100 + r), 16'h0);
      s_dat = 16'h5000 + 16'(r);
      s_ack = 1'b0;
      exp_q.push_back(16'h5000 + 16'(r));
      #1;
      check("both_idle_no_stb", 32'(s_stb), 0);
      @(negedge clk_p); #1;
      check("both_grant", 32'(dbg_state), 32'(gnt_of(win)));
      s_ack = 1'b1;
      #1;
      check("both_win_ack", 32'(ack_of(win)), 1);
      check("both_lose_ack", 32'(ack_of(!win)), 0);
      check("both_lose_rdat", 32'(rdat_of(!win)), 0);
      sb_pop("both_rd_data", rdat_of(win));
      @(negedge clk_p);
      set_stb(win, 1'b0);
      if (r == 2) set_stb(!win, 1'b0);
      s_ack = 1'b0;
      @(negedge clk_p); #1;
      check("both_rel", 32'(dbg_state), 32'(ST_REL));
      @(negedge clk_p); #1;
      check("both_idle", 32'(dbg_state), 32'(ST_IDLE));
    end

    // ---- timeout: no s_ack, err after the 8th stalled grant cycle ----
    @(negedge clk_p);
    drive_req(1'b0, 1'b0, 2'b11, 21'h00200, 16'h0);
    s_ack = 1'b0;
    @(negedge clk_p); #1;
    for (int c = 1; c <= TMO; c++) begin
      check("tmo_gnt_state", 32'(dbg_state), 32'(ST_GNT0));
      check("tmo_no_err_yet", 32'(m0_err), 0);
      @(negedge clk_p); #1;
    end
    check("tmo_err_pulse", 32'(m0_err), 1);
    check("tmo_m1_err", 32'(m1_err), 0);
    check("tmo_rel_state", 32'(dbg_state), 32'(ST_REL));
    check("tmo_s_stb_drop", 32'(s_stb), 0);
    @(negedge clk_p); #1;
    check("tmo_err_single", 32'(m0_err), 0);
    check("tmo_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk_p); #1;
    check("tmo_regrant", 32'(dbg_state), 32'(ST_GNT0));
    check("tmo_regrant_stb", 32'(s_stb), 1);
    s_dat = 16'h4242;
    exp_q.push_back(16'h4242);
    s_ack = 1'b1;
    #1;
    check("tmo_regrant_ack", 32'(m0_ack), 1);
    sb_pop("tmo_regrant_rdat", m0_rdat);
    release_req(1'b0, "tmo");

    // ---- ack arriving in the limit cycle wins over the timeout ----
    @(negedge clk_p);
    drive_req(1'b0, 1'b0, 2'b11, 21'h00300, 16'h0);
    s_ack = 1'b0;
    @(negedge clk_p);
    repeat (TMO - 1) @(negedge clk_p);
    s_ack = 1'b1;
    #1;
    check("ackwin_ack", 32'(m0_ack), 1);
    @(negedge clk_p); #1;
    check("ackwin_no_err", 32'(m0_err), 0);
    check("ackwin_still_gnt", 32'(dbg_state), 32'(ST_GNT0));
    release_req(1'b0, "ackwin");
    check("ackwin_no_err_after", 32'(m0_err), 0);

    // ---- s_ready low holds the arbiter in IDLE ----
    @(negedge clk_p);
    s_ready = 1'b0;
    drive_req(1'b0, 1'b0, 2'b11, 21'h00400, 16'h0);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("nrdy_no_stb", 32'(s_stb), 0);
      check("nrdy_idle", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk_p);
    end
    s_ready = 1'b1;
    #1;
    check("nrdy_rise_no_stb", 32'(s_stb), 0);
    @(negedge clk_p); #1;
    check("nrdy_grant", 32'(dbg_state), 32'(ST_GNT0));
    check("nrdy_grant_stb", 32'(s_stb), 1);
    s_ack = 1'b1;
    release_req(1'b0, "nrdy");

    // ---- reset asserted during GNT1 ----
    @(negedge clk_p);
    drive_req(1'b1, 1'b1, 2'b11, 21'h12345, 16'hCAFE);
    s_ack = 1'b0;
    @(negedge clk_p); #1;
    check("rstmid_gnt1", 32'(dbg_state), 32'(ST_GNT1));
    check("rstmid_stb_before", 32'(s_stb), 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_stb_drop", 32'(s_stb), 0);
    check("rstmid_idle", 32'(dbg_state), 32'(ST_IDLE));
    m1_stb = 1'b0;
    @(negedge clk_p);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rstrel_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("rstrel_no_ack", 32'({m0_ack, m1_ack}), 0);
      check("rstrel_no_err", 32'({m0_err, m1_err}), 0);
      @(negedge clk_p);
    end

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
